// File: rtl/safe_ctrl_pkg.sv
// Shared types for the safe-FSM sequencing controller: driven-machine states,
// controller states and the single-step plan record.
package safe_ctrl_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAN    = 3'd1,
    DRIVE   = 3'd2,
    CHECK   = 3'd3,
    RECOVER = 3'd4,
    RESP    = 3'd5
  } ctrl_t;

  // One planned move: either reset the machine, or apply drv_bit and expect exp_state.
  typedef struct packed {
    logic   to_reset;
    logic   drv_bit;
    state_t exp_state;
    logic   at_target;
  } step_t;

endpackage

// File: rtl/safe_step_planner.sv
// Combinational next-move planner: given the observed state and the target,
// pick the single data_in bit (or a reset) that moves the machine closer.
module safe_step_planner
  import safe_ctrl_pkg::*;
(
  input  logic [1:0] cur,
  input  logic [1:0] target,
  output step_t      step
);

  always_comb begin
    step = '0;
    if (cur == target) begin
      step.at_target = 1'b1;
    end else if (target == S0) begin
      // S0 is only reachable through the machine's reset.
      step.to_reset  = 1'b1;
      step.exp_state = S0;
    end else begin
      case (state_t'(cur))
        S0: begin
          step.drv_bit   = 1'b0;
          step.exp_state = S1;
        end
        S1: begin
          step.drv_bit   = 1'b1;
          step.exp_state = S2;
        end
        S2: begin
          if (target == S1) begin
            step.drv_bit   = 1'b0;
            step.exp_state = S1;
          end else begin
            step.drv_bit   = 1'b1;
            step.exp_state = S3;
          end
        end
        default: begin
          step.drv_bit   = 1'b1;
          step.exp_state = S2;
        end
      endcase
    end
  end

endmodule

// File: rtl/safe_fsm_ctrl.sv
// Sequencing controller that walks one 2-bit safe FSM to a requested state,
// verifying each step and recovering through the machine's reset on mismatch.
module safe_fsm_ctrl
  import safe_ctrl_pkg::*;
#(
  parameter int MAX_RETRY = 2,
  parameter int MAX_STEPS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_target,
  output logic       req_ready,
  input  logic [1:0] fsm_state,
  output logic       fsm_data_in,
  output logic       fsm_reset,
  output logic       done,
  output logic       err,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int SW = (MAX_STEPS < 1) ? 1 : $clog2(MAX_STEPS + 1);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // req_ready is high only in IDLE, req_valid while busy is neither taken nor queued.
  ctrl_t          state_q, state_d;
  state_t         target_q, exp_q;
  logic [RW-1:0]  retry_cnt;
  logic [SW-1:0]  step_cnt;
  logic           err_q, err_d;
  logic           retry_inc, step_inc;
  step_t          plan;

  safe_step_planner u_planner (
    .cur    (fsm_state),
    .target (target_q),
    .step   (plan)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    retry_inc = 1'b0;
    step_inc  = 1'b0;
    case (state_q)
      IDLE: if (req_valid) state_d = PLAN;
      PLAN: begin
        if (plan.at_target) begin
          state_d = RESP;
          err_d   = 1'b0;
        end else if (plan.to_reset) begin
          state_d = RECOVER;
        end else if (step_cnt == SW'(MAX_STEPS)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        step_inc = 1'b1;
        state_d  = CHECK;
      end
      RECOVER: state_d = CHECK;
      CHECK: begin
        if (fsm_state == exp_q) begin
          state_d = PLAN;
        end else if (retry_cnt == RW'(MAX_RETRY)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          retry_inc = 1'b1;
          state_d   = RECOVER;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= S0;
      exp_q       <= S0;
      retry_cnt   <= '0;
      step_cnt    <= '0;
      err_q       <= 1'b0;
      fsm_data_in <= 1'b0;
      fsm_reset   <= 1'b1;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == IDLE && req_valid) begin
        target_q  <= state_t'(req_target);
        retry_cnt <= '0;
        step_cnt  <= '0;
      end
      if (step_inc && step_cnt != SW'(MAX_STEPS)) step_cnt <= step_cnt + SW'(1);
      if (retry_inc && retry_cnt != RW'(MAX_RETRY)) retry_cnt <= retry_cnt + RW'(1);
      if (state_d == DRIVE) exp_q <= plan.exp_state;
      else if (state_d == RECOVER) exp_q <= S0;
      // Outputs are registered from the next state so they line up with that state's cycle.
      fsm_data_in <= (state_d == DRIVE) ? plan.drv_bit : 1'b0;
      if (state_d == DRIVE) fsm_reset <= 1'b0;
      else if (state_d == RECOVER) fsm_reset <= 1'b1;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign done      = (state_q == RESP);
  assign err       = done & err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_safe_fsm_ctrl.sv
// Bench for safe_fsm_ctrl: a behavioural safe-FSM plant plus a path-level
// reference model of the walk each request should produce.
module tb_safe_fsm_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_target = 2'd0;
  logic       req_ready, fsm_data_in, fsm_reset, done, err, busy;
  logic [1:0] fsm_state;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [63:0] ob_din, ob_rst, ob_done, ob_err, ob_busy, lim_mask;
  logic [1:0]  exp_q[$];
  int          cur_st;
  logic        cur_rst;

  // plant
  logic [1:0] plant_st = 2'd0;
  logic       plant_stuck = 1'b0;
  logic       step_en = 1'b0;

  always #5 clk = ~clk;

  safe_fsm_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_target  (req_target),
    .req_ready   (req_ready),
    .fsm_state   (fsm_state),
    .fsm_data_in (fsm_data_in),
    .fsm_reset   (fsm_reset),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  assign fsm_state = plant_st;

  function automatic logic [1:0] plant_next(input logic [1:0] s, input logic d);
    case (s)
      2'd0:    plant_next = d ? 2'd0 : 2'd1;
      2'd1:    plant_next = d ? 2'd2 : 2'd1;
      2'd2:    plant_next = d ? 2'd3 : 2'd1;
      default: plant_next = d ? 2'd2 : 2'd3;
    endcase
  endfunction

  // The plant steps on its data_in only in cycles where the walk applies a move.
  always @(posedge clk) begin
    if (plant_stuck) plant_st <= plant_st;
    else if (fsm_reset) plant_st <= 2'd0;
    else if (step_en) plant_st <= plant_next(plant_st, fsm_data_in);
  end

  // Reference: walk along S0-S1-S2-S3 one position per move (3 cycles each),
  // S0 only via reset (done in cycle 5), already-there done in cycle 2.
  function automatic void model_req(input int cur, input int tgt, input logic rst0,
                                    output int n, output logic [63:0] din_e,
                                    output logic [63:0] rst_e, output logic [63:0] drv_e);
    int s, c;
    s = cur; c = 2;
    din_e = '0; drv_e = '0;
    for (int i = 0; i < 64; i++) rst_e[i] = rst0;
    if (cur == tgt) begin
      n = 2;
    end else if (tgt == 0) begin
      for (int i = 2; i < 64; i++) rst_e[i] = 1'b1;
      n = 5;
    end else begin
      for (int i = 2; i < 64; i++) rst_e[i] = 1'b0;
      for (int k = 0; k < 3 && s != tgt; k++) begin
        drv_e[c] = 1'b1;
        if (tgt > s) begin
          din_e[c] = (s != 0);
          s++;
        end else begin
          din_e[c] = (s == 3);
          s--;
        end
        c += 3;
      end
      n = c;
    end
  endfunction

  function automatic logic [63:0] busy_vec(input int n);
    busy_vec = '0;
    for (int i = 1; i <= n; i++) busy_vec[i] = 1'b1;
  endfunction

  task automatic send_req(input int tgt, input logic [63:0] drv, input int limit);
    ob_din = '0; ob_rst = '0; ob_done = '0; ob_err = '0; ob_busy = '0; lim_mask = '0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_target = 2'(tgt);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      req_target  = 2'($urandom_range(0, 3));
      lim_mask[c] = 1'b1;
      ob_din[c]   = fsm_data_in;
      ob_rst[c]   = fsm_reset;
      ob_done[c]  = done;
      ob_err[c]   = err;
      ob_busy[c]  = busy;
      step_en     = drv[c];
    end
    step_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
    checks++; if (fsm_data_in !== 1'b0) begin errors++; $display("FAIL reset_din got=%b exp=0", fsm_data_in); end
    checks++; if (fsm_reset !== 1'b1) begin errors++; $display("FAIL reset_fsm_reset got=%b exp=1", fsm_reset); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_plant got=%0d exp=0", fsm_state); end
    cur_st = 0; cur_rst = 1'b1;
  endtask

  task automatic test_walk(input string name, input int tgt, input int n_req);
    int n; logic [63:0] din_e, rst_e, drv_e;
    model_req(cur_st, tgt, cur_rst, n, din_e, rst_e, drv_e);
    send_req(tgt, drv_e, n_req + 3);
    checks++; if (ob_din !== (din_e & lim_mask)) begin errors++; $display("FAIL %s_din got=%h exp=%h", name, ob_din, din_e & lim_mask); end
    checks++; if (ob_rst !== (rst_e & lim_mask)) begin errors++; $display("FAIL %s_rst got=%h exp=%h", name, ob_rst, rst_e & lim_mask); end
    checks++; if (ob_done !== (64'd1 << n_req)) begin errors++; $display("FAIL %s_done got=%h exp=%h", name, ob_done, 64'd1 << n_req); end
    checks++; if (ob_err !== 64'd0) begin errors++; $display("FAIL %s_err got=%h exp=0", name, ob_err); end
    checks++; if (ob_busy !== busy_vec(n_req)) begin errors++; $display("FAIL %s_busy got=%h exp=%h", name, ob_busy, busy_vec(n_req)); end
    checks++; if (int'(fsm_state) !== tgt) begin errors++; $display("FAIL %s_final got=%0d exp=%0d", name, fsm_state, tgt); end
    cur_st = tgt; cur_rst = rst_e[n];
  endtask

  task automatic test_reset_then_s3;  test_walk("s0_to_s3", 3, 11); endtask
  task automatic test_s3_to_s1;       test_walk("s3_to_s1", 1, 8);  endtask

  task automatic test_same_target;
    test_walk("s1_to_s2", 2, 5);
    test_walk("s2_same", 2, 2);
  endtask

  task automatic test_park;
    int hold;
    test_walk("park_s0", 0, 5);
    hold = 0;
    repeat (20) begin
      @(negedge clk);
      if (fsm_reset === 1'b1) hold++;
    end
    checks++; if (hold !== 20) begin errors++; $display("FAIL park_hold got=%0d exp=20", hold); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL park_plant got=%0d exp=0", fsm_state); end
    test_walk("park_leave", 1, 5);
  endtask

  task automatic test_stuck;
    logic [63:0] rst_e;
    plant_stuck = 1'b1;
    send_req(3, 64'd0, 10);
    rst_e = '0;
    for (int i = 4; i <= 10; i++) rst_e[i] = 1'b1;
    checks++; if (ob_din !== (64'd1 << 2)) begin errors++; $display("FAIL stuck_din got=%h exp=%h", ob_din, 64'd1 << 2); end
    checks++; if (ob_rst !== rst_e) begin errors++; $display("FAIL stuck_rst got=%h exp=%h", ob_rst, rst_e); end
    checks++; if (ob_done !== (64'd1 << 8)) begin errors++; $display("FAIL stuck_done got=%h exp=%h", ob_done, 64'd1 << 8); end
    checks++; if (ob_err !== (64'd1 << 8)) begin errors++; $display("FAIL stuck_err got=%h exp=%h", ob_err, 64'd1 << 8); end
    checks++; if (fsm_state !== 2'd1) begin errors++; $display("FAIL stuck_plant got=%0d exp=1", fsm_state); end
    plant_stuck = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL unstuck_plant got=%0d exp=0", fsm_state); end
    cur_st = 0; cur_rst = 1'b1;
  endtask

  task automatic test_reset_mid;
    int dn;
    @(negedge clk);
    req_valid = 1'b1; req_target = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (fsm_reset !== 1'b0 || fsm_data_in !== 1'b0) begin errors++; $display("FAIL mid_drive got=%b%b exp=00", fsm_reset, fsm_data_in); end
    step_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", req_ready); end
    checks++; if (fsm_reset !== 1'b1) begin errors++; $display("FAIL mid_fsm_reset got=%b exp=1", fsm_reset); end
    checks++; if (fsm_data_in !== 1'b0) begin errors++; $display("FAIL mid_din got=%b exp=0", fsm_data_in); end
    dn = (done === 1'b1) ? 1 : 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL mid_no_done got=%0d exp=0", dn); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL mid_plant got=%0d exp=0", fsm_state); end
    cur_st = 0; cur_rst = 1'b1;
  endtask

  task automatic test_random;
    int tgt, n; logic [63:0] din_e, rst_e, drv_e; logic [1:0] want;
    for (int k = 0; k < 24; k++) begin
      tgt = int'($urandom_range(0, 3));
      model_req(cur_st, tgt, cur_rst, n, din_e, rst_e, drv_e);
      exp_q.push_back(2'(tgt));
      send_req(tgt, drv_e, n + 2);
      checks++; if (ob_din !== (din_e & lim_mask)) begin errors++; $display("FAIL rnd%0d_din got=%h exp=%h", k, ob_din, din_e & lim_mask); end
      checks++; if (ob_rst !== (rst_e & lim_mask)) begin errors++; $display("FAIL rnd%0d_rst got=%h exp=%h", k, ob_rst, rst_e & lim_mask); end
      checks++; if (ob_done !== (64'd1 << n) || ob_err !== 64'd0) begin errors++; $display("FAIL rnd%0d_done got=%h/%h exp=%h/0", k, ob_done, ob_err, 64'd1 << n); end
      want = exp_q.pop_front();
      checks++; if (fsm_state !== want) begin errors++; $display("FAIL rnd%0d_final got=%0d exp=%0d", k, fsm_state, want); end
      cur_st = tgt; cur_rst = rst_e[n];
    end
  endtask

  initial begin
    test_reset;
    test_reset_then_s3;
    test_s3_to_s1;
    test_same_target;
    test_park;
    test_stuck;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
